// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus between the ALU controller and seq_divider.
`timescale 1ns/1ps
interface seq_divider_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, with a start/busy/done handshake.
`timescale 1ns/1ps
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zf_q, zf_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   rs, nd, t;
  logic             accept;

  // Stored remainder is always < D, so only the shifted value needs the extra bit.
  always_comb begin : sub_chain
    logic c;
    rs = {r_q, q_q[WIDTH-1]};
    nd = ~{1'b0, d_q};
    t  = '0;
    c  = 1'b1;
    for (int unsigned i = 0; i <= WIDTH; i++) begin
      t[i] = rs[i] ^ nd[i] ^ c;
      c    = (rs[i] & nd[i]) | (c & (rs[i] ^ nd[i]));
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    zf_d    = zf_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    accept  = bus.start && (state_q != CALC);

    case (state_q)
      CALC: begin
        q_d   = {q_q[WIDTH-2:0], ~t[WIDTH]};
        r_d   = t[WIDTH] ? rs[WIDTH-1:0] : t[WIDTH-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIN;
      end
      FIN: begin
        done_d  = 1'b1;
        quo_d   = q_q;
        rem_d   = r_q;
        dbz_d   = zf_q;
        state_d = IDLE;
      end
      default: ;
    endcase

    // A start taken in FIN still publishes the finishing result, including its zero flag.
    if (accept) begin
      q_d     = bus.dividend;
      d_d     = bus.divisor;
      r_d     = '0;
      cnt_d   = CW'(WIDTH - 1);
      zf_d    = 1'b0;
      state_d = CALC;
      if (state_q != FIN) dbz_d = 1'b0;
      if (bus.divisor == '0) begin
        q_d     = '1;
        r_d     = bus.dividend;
        zf_d    = 1'b1;
        state_d = FIN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      zf_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      zf_q    <= zf_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = (state_q == CALC);
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed cases plus random operands against an arithmetic reference.
`timescale 1ns/1ps
module tb_seq_divider;
  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int unsigned  due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus ();
  seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t        sb[$];
  exp_t        got;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  bit          norm_valid = 1'b0;
  int unsigned last_e = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected result is queued only if the start lands outside an ongoing division.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    int unsigned ed;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    ed = cyc;
    if (!(norm_valid && ed >= last_e + 1 && ed <= last_e + W)) begin
      e.a = a;
      e.b = b;
      if (b == '0) begin
        e.q = '1; e.r = a; e.z = 1'b1; e.due = ed + 1;
      end else begin
        e.q = a / b; e.r = a % b; e.z = 1'b0; e.due = ed + W + 1;
        norm_valid = 1'b1;
        last_e     = ed;
      end
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst quotient", bus.quotient, 0);
    chk("rst remainder", bus.remainder, 0);
    chk("rst div_by_zero", bus.div_by_zero, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", bus.busy, (norm_valid && cyc >= last_e && cyc <= last_e + W - 1));
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected done", bus.done, 0);
        end else begin
          got = sb.pop_front();
          chk("quotient", bus.quotient, got.q);
          chk("remainder", bus.remainder, got.r);
          chk("div_by_zero", bus.div_by_zero, got.z);
          chk("latency", cyc, got.due);
          if (!got.z) begin
            chk("invariant", 32'(bus.quotient) * 32'(got.b) + 32'(bus.remainder), 32'(got.a));
            chk("rem<div", bus.remainder < got.b, 1);
          end
        end
      end else if (sb.size() != 0 && cyc >= sb[0].due) begin
        chk("missing done", bus.done, 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    #2 rst_n = 1'b1;

    issue(16'd100, 16'd7);     wait_idle();
    issue(16'hFFFF, 16'd1);    wait_idle();
    issue(16'd5, 16'd9);       wait_idle();
    issue(16'h1234, 16'd0);    wait_idle();
    issue(16'd10, 16'd3);      wait_idle();

    issue(16'd1000, 16'd10);
    repeat (4) @(negedge clk);
    issue(16'd77, 16'd3);
    wait_idle();

    issue(16'd500, 16'd7);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    norm_valid = 1'b0;
    sb.delete();
    #1 chk_reset_outputs();
    @(negedge clk);
    #2 rst_n = 1'b1;
    issue(16'd45, 16'd6);      wait_idle();

    issue(16'd50, 16'd8);
    repeat (W) @(negedge clk);
    issue(16'd81, 16'd9);
    wait_idle();

    for (int n = 0; n < 2000; n++) begin
      a = W'($urandom);
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = a;
        3:       a = W'($urandom_range(0, 255));
        default: b = W'($urandom);
      endcase
      if (b == a && $urandom_range(0, 1) == 0) b = W'($urandom);
      issue(a, b);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
